ahb_lite_master: RTL

Single-outstanding AHB-Lite initiator that converts a simple command/response interface into AHB-Lite single transfers. It is the initiating end of the bus that our AHB-Lite peripherals respond to. It lets a local engine (DMA-lite, debug bridge, test sequencer) issue byte, halfword and word reads and writes. The block does lane placement of write data and lane extraction of read data, so the command side always uses LSB-aligned data.

---
 rtl/ahb_lite_pkg.sv | 21 ++
 rtl/ahb_lane_align.sv | 46 ++++
 rtl/ahb_lite_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the initiator FSM state type.
package ahb_lite_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering between LSB-aligned command data and the 32-bit AHB data buses.
module ahb_lane_align
  import ahb_lite_pkg::*;
(
  input  logic [1:0]        cmd_size_i,
  input  logic [1:0]        cmd_off_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [1:0]        rd_size_i,
  input  logic [1:0]        rd_off_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_lanes_c_o,
  output logic [DATA_W-1:0] rdata_ext_c_o,
  output logic              misaligned_c_o
);

  // Narrow writes are replicated so every lane the slave may pick holds the data.
  always_comb begin
    wdata_lanes_c_o = cmd_wdata_i;
    case (cmd_size_i)
      SIZE_BYTE: wdata_lanes_c_o = {4{cmd_wdata_i[7:0]}};
      SIZE_HALF: wdata_lanes_c_o = {2{cmd_wdata_i[15:0]}};
      default:   wdata_lanes_c_o = cmd_wdata_i;
    endcase
  end

  always_comb begin
    rdata_ext_c_o = rdata_i;
    case (rd_size_i)
      SIZE_BYTE: rdata_ext_c_o = {24'h0, rdata_i[{rd_off_i, 3'b000} +: 8]};
      SIZE_HALF: rdata_ext_c_o = {16'h0, rdata_i[{rd_off_i[1], 4'b0000} +: 16]};
      default:   rdata_ext_c_o = rdata_i;
    endcase
  end

  // Size 3 is never legal; otherwise the address must be naturally aligned.
  always_comb begin
    misaligned_c_o = 1'b0;
    case (cmd_size_i)
      SIZE_BYTE: misaligned_c_o = 1'b0;
      SIZE_HALF: misaligned_c_o = cmd_off_i[0];
      SIZE_WORD: misaligned_c_o = (cmd_off_i != 2'b00);
      default:   misaligned_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one command in, one SINGLE transfer out, one response back.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdWrite,
  input  logic [ADDR_WIDTH-1:0] cmdAddr,
  input  logic [1:0]            cmdSize,
  input  logic [DATA_W-1:0]     cmdWdata,
  output logic                  rspValid,
  output logic [DATA_W-1:0]     rspRdata,
  output logic                  rspErr,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [DATA_W-1:0]     HWDATA,
  input  logic [DATA_W-1:0]     HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
  logic [1:0]              htrans_q, htrans_d;
  logic                    hwrite_q, hwrite_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [DATA_W-1:0]       hwdata_q, hwdata_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0]       wdata_lanes_c;
  logic [DATA_W-1:0]       rdata_ext_c;
  logic                    misaligned_c;

  // HADDR/HSIZE stay stable through the data phase, so they drive read extraction.
  ahb_lane_align u_align (
    .cmd_size_i      (cmdSize),
    .cmd_off_i       (cmdAddr[1:0]),
    .cmd_wdata_i     (cmdWdata),
    .rd_size_i       (hsize_q[1:0]),
    .rd_off_i        (haddr_q[1:0]),
    .rdata_i         (HRDATA),
    .wdata_lanes_c_o (wdata_lanes_c),
    .rdata_ext_c_o   (rdata_ext_c),
    .misaligned_c_o  (misaligned_c)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (cmdValid) begin
          if (misaligned_c) begin
            // Rejected locally: respond with an error and never touch the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            haddr_d  = cmdAddr;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = cmdWrite;
            hsize_d  = {1'b0, cmdSize};
            wdata_d  = wdata_lanes_c;
            state_d  = ADDR;
          end
        end
      end

      ADDR: begin
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
          state_d = DATA;
        end
      end

      DATA: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = HRESP;
          if (!HRESP && !hwrite_q) begin
            rsp_rdata_d = rdata_ext_c;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmdReady  = (state_q == IDLE);
  assign rspValid  = rsp_valid_q;
  assign rspErr    = rsp_err_q;
  assign rspRdata  = rsp_rdata_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VALUE;
  assign HMASTLOCK = 1'b0;

endmodule
